ysyx_22041207_if_id_queue: RTL and testbench

//   Instruction queue between the fetch stage and the decode stage.

---
 rtl/ysyx_22041207_defs.sv | 13 +
 rtl/ysyx_22041207_ifq_ram.sv | 25 ++
 rtl/ysyx_22041207_if_id_queue.sv | 97 +++++++++
 tb/tb_ysyx_22041207_if_id_queue.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041207_defs.sv
// Shared constants for the fetch/decode front end: NOP encoding, boot pc,
// and the pointer-width helper used by the instruction queue.
package ysyx_22041207_defs;

  localparam logic [31:0] NOP_INST = 32'h00000013;
  localparam logic [63:0] RESET_PC = 64'h80000000;

  // One extra pointer bit distinguishes full from empty when the low bits match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ysyx_22041207_ifq_ram.sv
// Instruction queue storage: DEPTH x W register array, one write port, one async read port.
// Write lands on the clock edge; read data follows the read address combinationally.
module ysyx_22041207_ifq_ram #(
  parameter int DEPTH = 2,
  parameter int W     = 97
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  logic [W-1:0]               i_wdata,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr,
  output logic [W-1:0]               o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ysyx_22041207_if_id_queue.sv
// Fetch->decode instruction FIFO with one-cycle flush; 1-cycle latency, in_ready never depends on out_ready.
// Optional IFQ_BYPASS_EN forwards fetch straight to decode when the queue is empty (0-cycle latency).
module ysyx_22041207_if_id_queue
  import ysyx_22041207_defs::*;
#(
  parameter int DEPTH  = 2,
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INST_W-1:0]          in_inst,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [INST_W-1:0]          out_inst,
  output logic                       out_misalign,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int AW    = PTR_W - 1;
  localparam int EW    = PC_W + INST_W + 1;
  localparam logic [INST_W-1:0] EMPTY_INST = (INST_W == 32) ? INST_W'(NOP_INST) : '0;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             w_empty;
  logic             w_full;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic [EW-1:0]    w_wdata;
  logic [EW-1:0]    w_rdata;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

`ifdef IFQ_BYPASS_EN
  assign w_bypass = w_empty && in_valid && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign in_ready  = !w_full && !flush;
  assign out_valid = (!w_empty && !flush) || w_bypass;
  assign w_pop     = !w_empty && !flush && out_ready;
  // A bypassed entry consumed by decode this cycle never touches storage.
  assign w_push    = in_valid && in_ready && !(w_bypass && out_ready);

  assign w_wdata = {(in_pc[1:0] != 2'b00), in_pc, in_inst};

  ysyx_22041207_ifq_ram #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  always_comb begin
    out_pc       = '0;
    out_inst     = EMPTY_INST;
    out_misalign = 1'b0;
    if (w_bypass) begin
      out_pc       = in_pc;
      out_inst     = in_inst;
      out_misalign = (in_pc[1:0] != 2'b00);
    end else if (!w_empty) begin
      {out_misalign, out_pc, out_inst} = w_rdata;
    end
  end

  assign count = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_if_id_queue.sv
// Self-checking bench for the fetch->decode instruction queue (DEPTH=2).
module tb_ysyx_22041207_if_id_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_misalign;
  logic [1:0]  count;

  ysyx_22041207_if_id_queue #(.DEPTH(2), .PC_W(64), .INST_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_inst      (in_inst),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_misalign (out_misalign),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        mis;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        vld;
    logic [63:0] pc;
    logic        fl;
    logic        ordy;
    logic        ir;
    logic        ov;
    logic [1:0]  cnt;
  } vec_t;
  vec_t tbl[11];

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'hA5A50003;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [63:0] pc, input logic fl, input logic ordy);
    in_valid  = vld;
    in_pc     = pc;
    in_inst   = inst_of(pc);
    flush     = fl;
    out_ready = ordy;
  endtask

  // Called mid-cycle: records handshakes against the scoreboard, then advances one edge.
  task automatic score_and_step(input string tag);
    sb_t e;
    if (in_valid && in_ready) begin
      e.pc = in_pc; e.inst = in_inst; e.mis = (in_pc[1:0] != 2'b00);
      sb.push_back(e);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk({tag, "_pop_unexpected"}, 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk({tag, "_pc"}, out_pc, e.pc);
        chk({tag, "_inst"}, {32'd0, out_inst}, {32'd0, e.inst});
        chk({tag, "_mis"}, {63'd0, out_misalign}, {63'd0, e.mis});
      end
    end
    if (flush) sb.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_ov;

    tbl[0]  = '{1'b0, 64'h0,        1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 64'h80000000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[2]  = '{1'b1, 64'h80000004, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1};
    tbl[3]  = '{1'b1, 64'h80000008, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
    tbl[4]  = '{1'b1, 64'h80000008, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2};
    tbl[5]  = '{1'b1, 64'h80000008, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1};
    tbl[6]  = '{1'b1, 64'h80000100, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2};
    tbl[7]  = '{1'b0, 64'h0,        1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
    tbl[8]  = '{1'b1, 64'h80000002, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[9]  = '{1'b1, 64'h80000008, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1};
    tbl[10] = '{1'b0, 64'h0,        1'b0, 1'b1, 1'b1, 1'b1, 2'd1};

    rst = 1'b1;
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Traffic, then an asynchronous reset partway through a cycle.
    drive(1'b1, 64'h80000040, 1'b0, 1'b0);
    score_and_step("pre_rst0");
    drive(1'b1, 64'h80000044, 1'b0, 1'b0);
    score_and_step("pre_rst1");
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_count", {62'd0, count}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_inst", {32'd0, out_inst}, 64'h13);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_mis", {63'd0, out_misalign}, 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_count", {62'd0, count}, 64'd0);
    chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("post_rst_out_inst", {32'd0, out_inst}, 64'h13);

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].vld, tbl[i].pc, tbl[i].fl, tbl[i].ordy);
      #3;
      exp_ov = tbl[i].ov;
`ifdef IFQ_BYPASS_EN
      if (tbl[i].cnt == 2'd0 && tbl[i].vld && !tbl[i].fl) exp_ov = 1'b1;
`endif
      chk($sformatf("row%0d_in_ready", i), {63'd0, in_ready}, {63'd0, tbl[i].ir});
      chk($sformatf("row%0d_out_valid", i), {63'd0, out_valid}, {63'd0, exp_ov});
      chk($sformatf("row%0d_count", i), {62'd0, count}, {62'd0, tbl[i].cnt});
      score_and_step($sformatf("row%0d", i));
    end

    // Empty queue, fetch and decode both active in the same cycle.
    drive(1'b1, 64'h80000010, 1'b0, 1'b1);
    #3;
    chk("byp_in_ready", {63'd0, in_ready}, 64'd1);
    chk("byp_count0", {62'd0, count}, 64'd0);
`ifdef IFQ_BYPASS_EN
    chk("byp_out_valid", {63'd0, out_valid}, 64'd1);
    score_and_step("byp_same");
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    #3;
    chk("byp_next_count", {62'd0, count}, 64'd0);
    chk("byp_next_out_valid", {63'd0, out_valid}, 64'd0);
    score_and_step("byp_next");
`else
    chk("nobyp_out_valid", {63'd0, out_valid}, 64'd0);
    score_and_step("nobyp_same");
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    #3;
    chk("nobyp_next_out_valid", {63'd0, out_valid}, 64'd1);
    chk("nobyp_next_count", {62'd0, count}, 64'd1);
    chk("nobyp_next_pc", out_pc, 64'h80000010);
    score_and_step("nobyp_hold");
    drive(1'b0, 64'h0, 1'b0, 1'b1);
    #3;
    score_and_step("nobyp_pop");
`endif

    drive(1'b0, 64'h0, 1'b0, 1'b0);
    #3;
    chk("end_count", {62'd0, count}, 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
